counter_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer that shares one CW-bit up-counter (the divide/tick

---
 rtl/counter_share_arb_if.sv | 20 ++
 rtl/counter_share_arb.sv | 98 +++++++++
 tb/tb_counter_share_arb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_share_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_share_arb_if: requester-side bus of the shared-counter arbiter |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface counter_share_arb_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] tc_in;
  logic [NREQ-1:0]    grant;
  logic [CW-1:0]      cnt;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport master (output req, tc_in, input grant, cnt, done, busy);
  modport slave  (input req, tc_in, output grant, cnt, done, busy);
endinterface
`default_nettype wire

// File: rtl/counter_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_share_arb: round-robin sharing of one up-counter among NREQ   |
// | requesters, each running it from 0 to its own terminal count.         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module counter_share_arb #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  counter_share_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_tc;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_winner;
  logic [CW-1:0]   w_tc [NREQ];

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_tc
      assign w_tc[g] = bus.tc_in[g*CW +: CW];
    end
  endgenerate

  // Scanning from the far end means the nearest set bit after r_ptr wins last.
  always_comb begin
    w_idx    = '0;
    w_winner = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = PW'((int'(r_ptr) + i) % NREQ);
      if (bus.req[w_idx]) w_winner = w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= PW'(NREQ - 1);
      r_tc      <= '0;
      bus.grant <= '0;
      bus.cnt   <= '0;
      bus.done  <= '0;
      bus.busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            bus.grant <= NREQ'(1) << w_winner;
            r_tc      <= w_tc[w_winner];
            r_ptr     <= w_winner;
            bus.cnt   <= '0;
            bus.busy  <= 1'b1;
            r_state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!bus.req[r_ptr]) begin
            bus.grant <= '0;
            bus.cnt   <= '0;
            bus.busy  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (bus.cnt == r_tc) begin
            bus.done  <= bus.grant;
            r_state   <= S_DONE;
          end else begin
            bus.cnt   <= bus.cnt + CW'(1);
          end
        end
        S_DONE: begin
          bus.grant <= '0;
          bus.done  <= '0;
          bus.cnt   <= '0;
          bus.busy  <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          bus.grant <= '0;
          bus.done  <= '0;
          bus.cnt   <= '0;
          bus.busy  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_counter_share_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_counter_share_arb: scoreboard bench for counter_share_arb          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_counter_share_arb;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_share_arb_if #(.NREQ(NREQ), .CW(CW)) bus ();

  counter_share_arb #(.NREQ(NREQ), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Packed view {grant[12:9], cnt[8:5], done[4:1], busy[0]}
  wire [12:0] obs = {bus.grant, bus.cnt, bus.done, bus.busy};
  logic [12:0] sb [$];
  logic [12:0] exp_v;

  // Expected trace of one completed run: tc+1 COUNT cycles then one DONE cycle
  task automatic push_run(input logic [3:0] g, input logic [3:0] tc);
    for (int t = 0; t <= int'(tc); t++) sb.push_back({g, 4'(t), 4'b0000, 1'b1});
    sb.push_back({g, tc, g, 1'b1});
  endtask

  task automatic push_idle();
    sb.push_back(13'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.tc_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (!$onehot0(bus.grant) || !$onehot0(bus.done) || ((bus.done & ~bus.grant) != 0)) begin
        errors++;
        $display("FAIL onehot: grant=%b done=%b must be one-hot/zero, done within grant", bus.grant, bus.done);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.tc_in = '0;
    @(negedge clk);
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs, 13'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, 13'b0);
    end
  endtask

  task automatic test_single();
    sb.delete();
    bus.tc_in[0*CW +: CW] = 4'd3;
    bus.req = 4'b0001;
    push_run(4'b0001, 4'd3);
    push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single: got %b want %b", obs, exp_v);
      end
      if (exp_v[4:1] != 0) bus.req = bus.req & ~exp_v[4:1];
    end
  endtask

  task automatic test_round_robin();
    int nd;
    nd = 0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) bus.tc_in[i*CW +: CW] = 4'd1;
    bus.req = 4'b1111;
    push_run(4'b0001, 4'd1); push_idle();
    push_run(4'b0010, 4'd1); push_idle();
    push_run(4'b0100, 4'd1); push_idle();
    push_run(4'b1000, 4'd1); push_idle();
    push_run(4'b0001, 4'd1); push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL round_robin: got %b want %b", obs, exp_v);
      end
      if (exp_v[4:1] != 0) begin
        nd++;
        if (nd == 5) bus.req = '0;
      end
    end
  endtask

  task automatic test_tc_bounds();
    sb.delete();
    bus.tc_in[2*CW +: CW] = 4'd0;
    bus.req = 4'b0100;
    push_run(4'b0100, 4'd0);
    push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tc_zero: got %b want %b", obs, exp_v);
      end
      if (exp_v[4:1] != 0) bus.req = bus.req & ~exp_v[4:1];
    end
    bus.tc_in[0*CW +: CW] = 4'd15;
    bus.req = 4'b0001;
    push_run(4'b0001, 4'd15);
    push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tc_max: got %b want %b", obs, exp_v);
      end
      if (exp_v[4:1] != 0) bus.req = bus.req & ~exp_v[4:1];
    end
  endtask

  task automatic test_abort();
    sb.delete();
    bus.tc_in[1*CW +: CW] = 4'd9;
    bus.req = 4'b0010;
    for (int t = 0; t <= 2; t++) sb.push_back({4'b0010, 4'(t), 4'b0000, 1'b1});
    push_idle();
    push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort: got %b want %b", obs, exp_v);
      end
      if (exp_v[0] && exp_v[8:5] == 4'd2) bus.req = '0;
    end
  endtask

  task automatic test_reset_mid_run();
    logic hit;
    hit = 1'b0;
    sb.delete();
    bus.tc_in[1*CW +: CW] = 4'd9;
    bus.req = 4'b0010;
    push_run(4'b0010, 4'd9);
    while (sb.size() > 0 && !hit) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL pre_reset: got %b want %b", obs, exp_v);
      end
      if (exp_v[8:5] == 4'd5) hit = 1'b1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", obs, 13'b0);
    end
    sb.delete();
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    bus.tc_in[1*CW +: CW] = 4'd1;
    bus.tc_in[3*CW +: CW] = 4'd1;
    bus.req = 4'b1010;
    push_run(4'b0010, 4'd1); push_idle();
    push_run(4'b1000, 4'd1); push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset: got %b want %b", obs, exp_v);
      end
      if (exp_v[4:1] != 0) bus.req = bus.req & ~exp_v[4:1];
    end
  endtask

  task automatic test_tc_change();
    sb.delete();
    bus.tc_in[0*CW +: CW] = 4'd6;
    bus.req = 4'b0001;
    push_run(4'b0001, 4'd6);
    push_idle();
    while (sb.size() > 0) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL tc_change: got %b want %b", obs, exp_v);
      end
      if (exp_v[0] && exp_v[4:1] == 0 && exp_v[8:5] == 4'd1) bus.tc_in[0*CW +: CW] = 4'd2;
      if (exp_v[4:1] != 0) bus.req = bus.req & ~exp_v[4:1];
    end
  endtask

  initial begin
    bus.req = '0;
    bus.tc_in = '0;
    test_reset();
    test_single();
    do_reset();
    test_round_robin();
    test_tc_bounds();
    test_abort();
    test_reset_mid_run();
    test_tc_change();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
